// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared types and helpers for the toggle-CDC source-side transmit controller.
//   tx_state_t : transmit FSM states (IDLE, SEND, WAIT_ACK)
//   cnt_width  : width of a FIFO occupancy count, $clog2(depth)+1, so that a
//                completely full FIFO is representable.
// -----------------------------------------------------------------------------
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } tx_state_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cdc_tx_fifo.sv
// -----------------------------------------------------------------------------
// cdc_tx_fifo
// Single-clock FIFO buffering words ahead of the CDC transmit FSM.
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full)
//   push_data  : word to write
//   pop        : advance read pointer (ignored when empty)
//   pop_data   : head word, valid whenever !empty
//   full/empty : occupancy flags
//   count      : occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module cdc_tx_fifo
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic [DATA_WIDTH-1:0]              pop_data,
    output logic                               full,
    output logic                               empty,
    output logic [cnt_width(FIFO_DEPTH)-1:0]   count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = cnt_width(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/cdc_data_tx_ctrl.sv
// -----------------------------------------------------------------------------
// cdc_data_tx_ctrl
// Source-domain front end of the toggle-based CDC data transfer. Words taken
// from a valid/ready stream are queued in a FIFO, then sent one at a time: a
// single-cycle xfer_enable per word, with xfer_data held until the return ack.
// The acknowledge wait is supervised by a saturating timeout counter.
//
// Ports:
//   clk, reset   : source clock, synchronous active-high reset
//   in_valid     : upstream word valid
//   in_data      : upstream word
//   in_ready     : FIFO can accept (== !full)
//   xfer_enable  : one-cycle request to the synchronizer
//   xfer_data    : word under transfer, changes only when a word is popped
//   ack          : one-cycle acknowledge from the destination side
//   err_clear    : clears timeout_err (a simultaneous set wins)
//   busy         : transfer outstanding (state != IDLE)
//   timeout_err  : sticky, ack not seen within ACK_TIMEOUT WAIT_ACK cycles
//   fifo_count   : FIFO occupancy
// ACK_TIMEOUT = 0 disables the timeout.
// -----------------------------------------------------------------------------
module cdc_data_tx_ctrl
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               in_ready,
    output logic                               xfer_enable,
    output logic [DATA_WIDTH-1:0]              xfer_data,
    input  logic                               ack,
    input  logic                               err_clear,
    output logic                               busy,
    output logic                               timeout_err,
    output logic [cnt_width(FIFO_DEPTH)-1:0]   fifo_count
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam int unsigned TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(ACK_TIMEOUT);

    tx_state_t             state_q,     state_d;
    logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic                  xfer_en_q,   xfer_en_d;
    logic [TW-1:0]         tmo_cnt_q,   tmo_cnt_d;
    logic                  err_q,       err_d;
    logic                  tmo_set;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;

    cdc_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    always_comb begin
        state_d     = state_q;
        xfer_data_d = xfer_data_q;
        xfer_en_d   = 1'b0;
        tmo_cnt_d   = '0;
        fifo_pop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ack here is stale (e.g. after a local reset) and is dropped
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    xfer_data_d = fifo_head;
                    xfer_en_d   = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // the request pulse is in flight; any ack now cannot be ours
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack) begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        xfer_data_d = fifo_head;
                        xfer_en_d   = 1'b1;
                        state_d     = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_cnt_q != TMO_LIMIT) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end else begin
                    tmo_cnt_d = tmo_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Level condition: while the counter sits saturated the flag keeps being
    // set, so err_clear only takes effect once the wait has ended.
    assign tmo_set = (ACK_TIMEOUT != 0) && (state_q == WAIT_ACK) && !ack &&
                     (tmo_cnt_d == TMO_LIMIT);

    always_comb begin
        err_d = err_q;
        if (tmo_set) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            xfer_data_q <= '0;
            xfer_en_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_data_q <= xfer_data_d;
            xfer_en_q   <= xfer_en_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign xfer_enable = xfer_en_q;
    assign xfer_data   = xfer_data_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;
    assign fifo_count  = fifo_cnt;

endmodule

// File: tb/tb_cdc_data_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdc_data_tx_ctrl
// Bench for cdc_data_tx_ctrl (DATA_WIDTH=8, FIFO_DEPTH=4, ACK_TIMEOUT=16).
// A negedge monitor keeps a queue of accepted words and checks that each
// xfer_enable carries the next one and that xfer_data holds during WAIT_ACK.
// A cycle table covers single word / stray acks; directed sequences cover
// fill, back-to-back timing, timeout and mid-transfer reset.
// -----------------------------------------------------------------------------
module tb_cdc_data_tx_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int          NV    = 11;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          ack       = 1'b0;
    logic          err_clear = 1'b0;
    logic          in_ready;
    logic          xfer_enable;
    logic [DW-1:0] xfer_data;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sb_exp;
    logic [DW-1:0] last_sent = '0;

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic          ack;
        logic          clr;
        logic          rdy;
        logic          en;
        logic [DW-1:0] xd;
        logic          bsy;
        logic          err;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[NV];

    always #5 clk = ~clk;

    cdc_data_tx_ctrl #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .xfer_enable (xfer_enable),
        .xfer_data   (xfer_data),
        .ack         (ack),
        .err_clear   (err_clear),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fifo_count  (fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic vld, input logic [DW-1:0] data, input logic a,
                                input logic clr, input logic rdy, input logic en,
                                input logic [DW-1:0] xd, input logic bsy, input logic err,
                                input logic [CW-1:0] cnt);
        vec_t v;
        v.vld = vld; v.data = data; v.ack = a;   v.clr = clr;
        v.rdy = rdy; v.en   = en;   v.xd  = xd;  v.bsy = bsy;
        v.err = err; v.cnt  = cnt;
        return v;
    endfunction

    // Scoreboard: inputs are stable at the negedge, so a push seen here lands
    // at the following posedge; outputs seen here reflect the previous edge.
    always @(negedge clk) begin
        if (xfer_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_xfer: got xfer_data 0x%0h want no transfer", xfer_data);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_xfer_data", xfer_data, sb_exp);
                last_sent = sb_exp;
            end
        end else if (busy === 1'b1) begin
            chk("sb_hold_data", xfer_data, last_sent);
        end
        if (reset) begin
            exp_q.delete();
        end else if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(in_data);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        err_clear = 1'b0;
        while ((busy !== 1'b0 || fifo_count !== '0) && n < 200) begin
            ack = (busy === 1'b1 && xfer_enable === 1'b0);
            step();
            n++;
        end
        ack = 1'b0;
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got busy=%0b count=%0d want idle and empty", busy, fifo_count);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},    in_ready,    1);
        chk({tag, "_xfer_enable"}, xfer_enable, 0);
        chk({tag, "_xfer_data"},   xfer_data,   0);
        chk({tag, "_busy"},        busy,        0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_fifo_count"},  fifo_count,  0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                vld  data   ack  clr  rdy  en   xd     bsy  err  cnt
        vecs[0]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0); // stray ack in IDLE
        vecs[1]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1); // push A5
        vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 3'd0); // SEND
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd0); // ack in SEND ignored
        vecs[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd0);
        vecs[5]  = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd1); // push while waiting
        vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 3'd0); // ack -> next word
        vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 3'd0); // ack in SEND ignored
        vecs[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 3'd0); // ack, empty -> IDLE
        vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 3'd0); // stray ack in IDLE
        vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 3'd0); // err_clear, no error

        // reset state
        step();
        step();
        reset = 1'b0;
        chk_reset_vals("rst");

        // cycle table
        for (int i = 0; i < NV; i++) begin
            in_valid  = vecs[i].vld;
            in_data   = vecs[i].data;
            ack       = vecs[i].ack;
            err_clear = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_in_ready", i),    in_ready,    vecs[i].rdy);
            chk($sformatf("vec%0d_xfer_enable", i), xfer_enable, vecs[i].en);
            chk($sformatf("vec%0d_xfer_data", i),   xfer_data,   vecs[i].xd);
            chk($sformatf("vec%0d_busy", i),        busy,        vecs[i].bsy);
            chk($sformatf("vec%0d_timeout_err", i), timeout_err, vecs[i].err);
            chk($sformatf("vec%0d_fifo_count", i),  fifo_count,  vecs[i].cnt);
        end
        in_valid  = 1'b0;
        ack       = 1'b0;
        err_clear = 1'b0;
        drain();

        // fill: one word in flight plus four queued, sixth word stalls
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'h10 + i);
            step();
        end
        chk("fill_count", fifo_count, 4);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_busy", busy, 1);
        in_data = 8'h15;
        for (int i = 0; i < 3; i++) step();
        chk("stall_count", fifo_count, 4);
        chk("stall_in_ready", in_ready, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("fill_ack_count", fifo_count, 3);
        chk("fill_ack_in_ready", in_ready, 1);
        chk("fill_ack_enable", xfer_enable, 1);
        chk("fill_ack_data", xfer_data, 8'h11);
        step();
        in_valid = 1'b0;
        chk("fill_refill_count", fifo_count, 4);
        chk("fill_refill_in_ready", in_ready, 0);
        drain();

        // back-to-back: acks at edges 10 and 20 launch the next word directly
        for (int k = 0; k < 25; k++) begin
            in_valid = (k < 3);
            in_data  = DW'(32'h20 + k);
            ack      = (k == 10 || k == 20);
            step();
            chk($sformatf("b2b_en_%0d", k), xfer_enable, (k == 1 || k == 10 || k == 20) ? 1 : 0);
            if (k >= 1) begin
                chk($sformatf("b2b_data_%0d", k), xfer_data, (k < 10) ? 8'h20 : (k < 20) ? 8'h21 : 8'h22);
            end
        end
        in_valid = 1'b0;
        ack      = 1'b0;
        drain();
        chk("b2b_no_err", timeout_err, 0);

        // timeout: 16 WAIT_ACK cycles sets the flag; late ack completes; clear
        for (int k = 0; k < 25; k++) begin
            in_valid  = (k == 0);
            in_data   = 8'h5A;
            err_clear = (k == 20 || k == 24);
            ack       = (k == 23);
            step();
            chk($sformatf("tmo_err_%0d", k), timeout_err, (k >= 18 && k < 24) ? 1 : 0);
            chk($sformatf("tmo_busy_%0d", k), busy, (k >= 1 && k < 23) ? 1 : 0);
        end
        in_valid  = 1'b0;
        err_clear = 1'b0;
        ack       = 1'b0;
        chk("tmo_data_held", xfer_data, 8'h5A);
        drain();

        // reset while waiting with two words queued; later ack is ignored
        for (int k = 0; k < 4; k++) begin
            in_valid = (k < 3);
            in_data  = DW'(32'h60 + k);
            step();
        end
        in_valid = 1'b0;
        chk("mid_count", fifo_count, 2);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("midrst");
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("post_rst_ack_busy", busy, 0);
        chk("post_rst_ack_en", xfer_enable, 0);
        chk("post_rst_ack_count", fifo_count, 0);
        chk("post_rst_ack_err", timeout_err, 0);
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_idle_en", xfer_enable, 0);
        chk("post_rst_idle_busy", busy, 0);

        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
